// File: rtl/work_loader_if.sv
// work_loader_if: host byte stream, solver control and result handshake of work_loader
interface work_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [255:0] midstate;
  logic [95:0] header_leftovers;
  logic [255:0] target;
  logic solver_rst_n;
  logic [2:0] solver_state;
  logic [31:0] solver_nonce;
  logic res_valid;
  logic res_ready;
  logic res_found;
  logic res_err;
  logic [31:0] res_nonce;
  modport master (
    output in_data, in_valid, res_ready, solver_state, solver_nonce,
    input in_ready, midstate, header_leftovers, target, solver_rst_n, res_valid, res_found, res_err, res_nonce
  );
  modport slave (
    input in_data, in_valid, res_ready, solver_state, solver_nonce,
    output in_ready, midstate, header_leftovers, target, solver_rst_n, res_valid, res_found, res_err, res_nonce
  );
endinterface

// File: rtl/work_loader.sv
// work_loader: loads a 44-byte work frame, expands nBits, runs block_solver and reports the result; RUN timeout under WORK_LOADER_TIMEOUT_EN
module work_loader
`ifdef WORK_LOADER_TIMEOUT_EN
  #(parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000)
`endif
(
  input logic clk,
  input logic rst_n,
  work_loader_if.slave bus
);
  localparam int FRAME_BYTES = 44;
  localparam logic [5:0] LAST = 6'(FRAME_BYTES - 1);
  typedef enum logic [1:0] {LOAD, EXPAND, RUN, DONE} state_t;
  state_t state, nxt;
  logic [5:0] cnt;
  logic [255:0] ms, tgt, m, shl, shr;
  logic [95:0] hl;
  logic [31:0] nbits, nonce;
  logic [10:0] e8;
  logic first, found, err, srst_n, bad, done_hit, tout;
  assign nbits = {hl[7:0], hl[15:8], hl[23:16], hl[31:24]};
  assign bad = nbits[31:24] == 8'd0 || nbits[31:24] > 8'd32 || nbits[23] || nbits[22:0] == 23'd0;
  assign m = {232'd0, nbits[23:0]};
  assign e8 = {nbits[31:24], 3'b000};
  assign shl = m << (e8 - 11'd24);
  assign shr = m >> (11'd24 - e8);
  assign done_hit = !first && (bus.solver_state == 3'd2 || bus.solver_state == 3'd3);
`ifdef WORK_LOADER_TIMEOUT_EN
  logic [31:0] tcnt;
  assign tout = tcnt == TIMEOUT_CYCLES - 32'd1;
  always_ff @(posedge clk)
    tcnt <= (!rst_n || state != RUN) ? 32'd0 : tcnt + 32'd1;
`else
  assign tout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      LOAD: if (bus.in_valid && cnt == LAST) nxt = EXPAND;
      EXPAND: nxt = bad ? DONE : RUN;
      RUN: if (done_hit || tout) nxt = DONE;
      DONE: if (bus.res_ready) nxt = LOAD;
      default: nxt = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt <= '0;
      ms <= '0;
      hl <= '0;
      tgt <= '0;
      first <= 1'b1;
      srst_n <= 1'b0;
      found <= 1'b0;
      err <= 1'b0;
      nonce <= '0;
    end else begin
      state <= nxt;
      srst_n <= nxt == RUN;
      first <= state != RUN;
      if (state == LOAD && bus.in_valid) begin
        {ms, hl} <= {ms[247:0], hl, bus.in_data};
        cnt <= cnt == LAST ? 6'd0 : cnt + 6'd1;
      end
      if (state == EXPAND) begin
        if (!bad) tgt <= nbits[31:24] >= 8'd3 ? shl : shr;
        err <= bad;
        found <= 1'b0;
        nonce <= '0;
      end
      if (state == RUN && nxt == DONE) begin
        found <= done_hit && bus.solver_state == 3'd2;
        err <= !done_hit;
        nonce <= bus.solver_nonce;
      end
    end
  end
  assign bus.in_ready = state == LOAD;
  assign bus.res_valid = state == DONE;
  assign bus.solver_rst_n = srst_n;
  assign bus.midstate = ms;
  assign bus.header_leftovers = hl;
  assign bus.target = tgt;
  assign bus.res_found = found;
  assign bus.res_err = err;
  assign bus.res_nonce = nonce;
endmodule

// File: tb/tb_work_loader.sv
// tb_work_loader: randomized frames against an arithmetic nBits/target model with a scripted solver
module tb_work_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  work_loader_if bus();
  work_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  logic [7:0] frame [44];
  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  function automatic logic [256:0] model(input logic [31:0] nb);
    logic [7:0] e;
    logic [23:0] mm;
    logic [255:0] t;
    logic b;
    e = nb[31:24];
    mm = nb[23:0];
    b = e == 0 || e > 32 || mm[23] || mm[22:0] == 0;
    t = 256'(mm);
    if (e >= 3) for (int k = 3; k < int'(e); k++) t = t * 256;
    else for (int k = int'(e); k < 3; k++) t = t / 256;
    return {b, t};
  endfunction
  task automatic build_frame(input logic [31:0] nb);
    for (int i = 0; i < 40; i++) frame[i] = 8'($urandom);
    frame[40] = nb[7:0];
    frame[41] = nb[15:8];
    frame[42] = nb[23:16];
    frame[43] = nb[31:24];
  endtask
  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        @(negedge clk);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL in_ready_load byte %0d got %b want 1", i, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data = frame[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic run_frame(input string name, input bit gaps, input bit fnd, input logic [31:0] start, input int lat, input int hold);
    logic [31:0] nb, en;
    logic [256:0] r;
    logic [255:0] ems;
    logic [95:0] ehl;
    logic ef, ee;
    nb = {frame[43], frame[42], frame[41], frame[40]};
    r = model(nb);
    for (int i = 0; i < 32; i++) ems[255 - 8 * i -: 8] = frame[i];
    for (int i = 0; i < 12; i++) ehl[95 - 8 * i -: 8] = frame[32 + i];
    bus.solver_state = 3'd2;
    bus.solver_nonce = 32'd0;
    send_bytes(44, gaps);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.solver_rst_n !== 1'b0 || bus.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s expand in_ready/solver_rst_n/res_valid got %b%b%b want 000", name, bus.in_ready, bus.solver_rst_n, bus.res_valid);
    end
    tests++;
    if (bus.midstate !== ems || bus.header_leftovers !== ehl) begin
      fails++;
      $display("FAIL %s frame got %h_%h want %h_%h", name, bus.midstate, bus.header_leftovers, ems, ehl);
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'($urandom);
    @(negedge clk);
    if (r[256]) begin
      ef = 1'b0;
      ee = 1'b1;
      en = 32'd0;
    end else begin
      ef = fnd;
      ee = 1'b0;
      en = start + 32'(lat);
      tests++;
      if (bus.solver_rst_n !== 1'b1 || bus.res_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s release solver_rst_n/res_valid got %b%b want 10", name, bus.solver_rst_n, bus.res_valid);
      end
      tests++;
      if (bus.target !== r[255:0]) begin
        fails++;
        $display("FAIL %s target got %h want %h", name, bus.target, r[255:0]);
      end
      @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s first_run_ignore res_valid got %b want 0", name, bus.res_valid);
      end
      bus.solver_state = 3'd1;
      bus.solver_nonce = start;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        tests++;
        if (bus.res_valid !== 1'b0 || bus.solver_rst_n !== 1'b1) begin
          fails++;
          $display("FAIL %s running res_valid/solver_rst_n got %b%b want 01", name, bus.res_valid, bus.solver_rst_n);
        end
        bus.solver_nonce = start + 32'(i + 1);
      end
      bus.solver_state = fnd ? 3'd2 : 3'd3;
      @(negedge clk);
      bus.solver_state = 3'd0;
    end
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_found !== ef || bus.res_err !== ee || bus.res_nonce !== en || bus.solver_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL %s result valid/found/err/nonce/srst got %b%b%b %h %b want 1%b%b %h 0", name, bus.res_valid, bus.res_found, bus.res_err, bus.res_nonce, bus.solver_rst_n, ef, ee, en);
    end
    tests++;
    if (bus.midstate !== ems || bus.header_leftovers !== ehl) begin
      fails++;
      $display("FAIL %s frame_stable got %h_%h want %h_%h", name, bus.midstate, bus.header_leftovers, ems, ehl);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_nonce !== en || bus.res_found !== ef || bus.res_err !== ee || bus.in_ready !== 1'b0 || bus.midstate !== ems) begin
        fails++;
        $display("FAIL %s hold cycle %0d valid/found/err/in_ready %b%b%b%b nonce %h want 1%b%b0 %h", name, i, bus.res_valid, bus.res_found, bus.res_err, bus.in_ready, bus.res_nonce, ef, ee, en);
      end
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    tests++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s handshake res_valid/in_ready got %b%b want 01", name, bus.res_valid, bus.in_ready);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.solver_rst_n !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_found !== 1'b0 || bus.res_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl in_ready/srst/valid/found/err got %b%b%b%b%b want 10000", bus.in_ready, bus.solver_rst_n, bus.res_valid, bus.res_found, bus.res_err);
    end
    tests++;
    if (bus.res_nonce !== 32'd0 || bus.midstate !== 256'd0 || bus.header_leftovers !== 96'd0 || bus.target !== 256'd0) begin
      fails++;
      $display("FAIL reset_data nonce %h ms %h hl %h tgt %h want all zero", bus.res_nonce, bus.midstate, bus.header_leftovers, bus.target);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_found();
    logic [63:0] mid;
    build_frame(32'h180440c4);
    mid = 64'h15274c646c51f957;
    for (int i = 0; i < 8; i++) frame[32 + i] = mid[63 - 8 * i -: 8];
    run_frame("known_found", 1'b0, 1'b1, 32'h9c9a4fc0, 0, 2);
    tests++;
    if (bus.target !== {64'h00000000000000000440c4, 168'd0}) begin
      fails++;
      $display("FAIL known_target got %h want 00000000000000000440c4 followed by zeros", bus.target);
    end
  endtask
  task automatic test_exhausted();
    run_frame("known_exhausted", 1'b0, 1'b0, 32'hfffffff0, 15, 1);
  endtask
  task automatic test_bad_nbits();
    build_frame(32'h21044000);
    run_frame("exp_33", 1'b0, 1'b1, 32'd0, 0, 1);
    build_frame(32'h0180ffff);
    run_frame("mant_sign", 1'b1, 1'b1, 32'd0, 0, 0);
    build_frame(32'h00123456);
    run_frame("exp_zero", 1'b0, 1'b1, 32'd0, 0, 0);
    build_frame(32'h05000000);
    run_frame("mant_zero", 1'b0, 1'b1, 32'd0, 0, 0);
  endtask
  task automatic test_exponent_edges();
    build_frame(32'h02123456);
    run_frame("exp_2", 1'b0, 1'b1, 32'h11111111, 1, 0);
    tests++;
    if (bus.target !== 256'h1234) begin
      fails++;
      $display("FAIL exp_2_target got %h want 1234", bus.target);
    end
    build_frame(32'h017fffff);
    run_frame("exp_1", 1'b0, 1'b0, 32'h22222222, 2, 0);
    build_frame(32'h03012345);
    run_frame("exp_3", 1'b1, 1'b1, 32'h33333333, 0, 0);
    build_frame(32'h207fffff);
    run_frame("exp_32", 1'b0, 1'b1, 32'h44444444, 3, 0);
  endtask
  task automatic test_gaps_reset();
    build_frame(32'h1d00ffff);
    send_bytes(20, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (bus.midstate !== 256'd0 || bus.header_leftovers !== 96'd0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midframe_reset ms %h hl %h in_ready %b want 0 0 1", bus.midstate, bus.header_leftovers, bus.in_ready);
    end
    build_frame(32'h1b0404cb);
    run_frame("after_reset_gaps", 1'b1, 1'b1, 32'h00abcdef, 4, 0);
  endtask
  task automatic test_run_reset();
    build_frame(32'h1d00ffff);
    bus.solver_state = 3'd1;
    send_bytes(44, 1'b0);
    @(negedge clk);
    tests++;
    if (bus.solver_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL run_reset_release solver_rst_n got %b want 1", bus.solver_rst_n);
    end
    @(negedge clk);
    bus.solver_state = 3'd2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.solver_state = 3'd0;
    tests++;
    if (bus.solver_rst_n !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL run_reset srst/valid/in_ready got %b%b%b want 001", bus.solver_rst_n, bus.res_valid, bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b0) begin
        fails++;
        $display("FAIL run_reset_quiet cycle %0d res_valid got %b want 0", i, bus.res_valid);
      end
    end
  endtask
  task automatic test_hold();
    build_frame(32'h1a01aa3d);
    run_frame("hold_10", 1'b0, 1'b1, 32'hdeadbeef, 2, 10);
  endtask
  task automatic test_random();
    logic [31:0] nb;
    for (int n = 0; n < 10; n++) begin
      nb[31:24] = 8'($urandom_range(0, 34));
      nb[23:0] = 24'($urandom) & 24'h7fffff;
      if ($urandom_range(0, 5) == 0) nb[23] = 1'b1;
      if ($urandom_range(0, 7) == 0) nb[22:0] = 23'd0;
      build_frame(nb);
      run_frame("random", 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
    end
  endtask
  initial begin
    bus.in_data = 8'd0;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.solver_state = 3'd0;
    bus.solver_nonce = 32'd0;
    test_reset();
    test_found();
    test_exhausted();
    test_bad_nbits();
    test_exponent_edges();
    test_gaps_reset();
    test_run_reset();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
